// File: rtl/uart_mmio_tx.sv
// UART 8N1/8N2 transmitter triggered by a rising edge on the MMIO write-enable level.
// Latency: the start bit appears on tx one cycle after the request cycle; all outputs are registered.
// Backpressure: none; a request arriving mid-frame is dropped and flagged by a one-cycle tx_ovr pulse.
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        tx,
  output logic        tx_busy,
  output logic        tx_done,
  output logic        tx_ovr
);

  // One counter serves both data bits and the (possibly double-length) stop period.
  localparam int CW = (CLKS_PER_BIT * STOP_BITS > 1) ? $clog2(CLKS_PER_BIT * STOP_BITS) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shreg_q, shreg_d;
  logic           wea_q;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           ovr_q, ovr_d;
  logic           req;

  // Only the low byte of the data word is transmitted.
  logic unused_dat_hi;
  assign unused_dat_hi = ^mmio_dat[31:8];

  // A held-high write-enable counts once; software must write 0 then 1 again.
  assign req = mmio_wea & ~wea_q;

  // Next-state logic; tx is computed one cycle ahead so the line itself comes from a flop.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ovr_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (req) begin
          shreg_d = mmio_dat[7:0];
          cnt_d   = '0;
          state_d = S_START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      S_START: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = S_DATA;
          tx_d      = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shreg_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (cnt_q == STOP_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Requests during a frame are dropped; the frame in flight is untouched.
    if (req && state_q != S_IDLE) begin
      ovr_d = 1'b1;
    end
  end

  // State and output registers; reset aborts any frame and parks the line high.
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shreg_q   <= 8'd0;
      wea_q     <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      wea_q     <= mmio_wea;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign tx_ovr  = ovr_q;

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Directed bench for uart_mmio_tx: C=4/1-stop instance for frame shape, holds, overrun, back-to-back, reset;
// a second C=868/2-stop instance checks long-frame widths.
// Outputs are sampled 1 time unit after each rising edge; inputs are changed at the same point.
module tb_uart_mmio_tx;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        mmio_wea = 1'b0;
  logic [31:0] mmio_dat = 32'h0;
  logic        tx, tx_busy, tx_done, tx_ovr;

  logic        wea2 = 1'b0;
  logic [31:0] dat2 = 32'h0;
  logic        tx2, busy2, done2, ovr2;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  uart_mmio_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
    .clk(clk), .Rst(Rst), .mmio_wea(mmio_wea), .mmio_dat(mmio_dat),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done), .tx_ovr(tx_ovr)
  );

  uart_mmio_tx #(.CLKS_PER_BIT(868), .STOP_BITS(2)) dut2 (
    .clk(clk), .Rst(Rst), .mmio_wea(wea2), .mmio_dat(dat2),
    .tx(tx2), .tx_busy(busy2), .tx_done(done2), .tx_ovr(ovr2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in request cycle N. seq holds the ten line values, start bit first in seq[9].
  // hold: keep mmio_wea high; ovr_at>0: drop wea at N+ovr_at and re-raise it with 0xFF one cycle later.
  task automatic frame(input logic [9:0] seq, input bit hold, input int ovr_at);
    for (int t = 1; t <= 40; t++) begin
      tick();
      if (!hold && t == 1) mmio_wea = 1'b0;
      if (t == 2) mmio_dat = 32'h1234_5678;
      if (ovr_at > 0 && t == ovr_at) mmio_wea = 1'b0;
      if (ovr_at > 0 && t == ovr_at + 1) begin
        mmio_wea = 1'b1;
        mmio_dat = 32'h0000_00FF;
      end
      chk("tx_bit", {31'd0, tx}, {31'd0, seq[9 - (t - 1) / 4]});
      chk("busy_in_frame", {31'd0, tx_busy}, 32'd1);
      chk("done_in_frame", {31'd0, tx_done}, 32'd0);
      chk("ovr_in_frame", {31'd0, tx_ovr}, (ovr_at > 0 && t == ovr_at + 2) ? 32'd1 : 32'd0);
    end
    tick();
    chk("busy_end", {31'd0, tx_busy}, 32'd0);
    chk("done_end", {31'd0, tx_done}, 32'd1);
    chk("tx_end", {31'd0, tx}, 32'd1);
    chk("ovr_end", {31'd0, tx_ovr}, 32'd0);
  endtask

  task automatic quiet(input int n, input string tag);
    int busy_seen = 0;
    int done_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_busy) busy_seen++;
      if (tx_done) done_seen++;
    end
    chk({tag, "_busy"}, busy_seen, 32'd0);
    chk({tag, "_done"}, done_seen, 32'd0);
  endtask

  initial begin
    int lo_cnt, hi_cnt, bsy_cnt, done_at;

    tick();
    tick();
    Rst = 1'b0;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_ovr", {31'd0, tx_ovr}, 32'd0);
    tick();

    // Basic 0xA5 frame, then hold wea high for 200 cycles: no retrigger.
    mmio_dat = 32'h0000_00A5;
    mmio_wea = 1'b1;
    frame(10'b0101001011, 1'b1, 0);
    quiet(200, "level_hold");

    // Fresh edge with 0x3C.
    mmio_wea = 1'b0;
    tick();
    mmio_dat = 32'h0000_003C;
    mmio_wea = 1'b1;
    frame(10'b0001111001, 1'b1, 0);

    // Overrun at N+11 with 0xFF; 0x55 frame intact and nothing follows.
    mmio_wea = 1'b0;
    tick();
    mmio_dat = 32'h0000_0055;
    mmio_wea = 1'b1;
    frame(10'b0101010101, 1'b1, 10);
    quiet(60, "after_ovr");

    // Back-to-back: new edge in the tx_done cycle is accepted.
    mmio_wea = 1'b0;
    tick();
    mmio_dat = 32'h0000_003C;
    mmio_wea = 1'b1;
    frame(10'b0001111001, 1'b0, 0);
    mmio_dat = 32'h0000_0081;
    mmio_wea = 1'b1;
    frame(10'b0100000011, 1'b0, 0);

    // Reset during data bit 3 (cycles N+17..N+20).
    tick();
    mmio_dat = 32'h0000_00A5;
    mmio_wea = 1'b1;
    for (int t = 1; t <= 18; t++) begin
      tick();
      if (t == 1) mmio_wea = 1'b0;
    end
    chk("pre_rst_busy", {31'd0, tx_busy}, 32'd1);
    Rst = 1'b1;
    tick();
    Rst = 1'b0;
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, tx_busy}, 32'd0);
    quiet(50, "after_rst");
    mmio_dat = 32'h0000_003C;
    mmio_wea = 1'b1;
    frame(10'b0001111001, 1'b0, 0);

    // Long frame: C=868, two stop bits, data 0x00.
    dat2 = 32'h0;
    wea2 = 1'b1;
    lo_cnt = 0;
    hi_cnt = 0;
    bsy_cnt = 0;
    done_at = 0;
    for (int t = 1; t <= 9600; t++) begin
      tick();
      if (t == 1) wea2 = 1'b0;
      if (busy2) bsy_cnt++;
      if (busy2 && !tx2) lo_cnt++;
      if (busy2 && tx2) hi_cnt++;
      if (done2 && done_at == 0) done_at = t;
    end
    chk("long_low", lo_cnt, 32'd7812);
    chk("long_stop", hi_cnt, 32'd1736);
    chk("long_busy", bsy_cnt, 32'd9548);
    chk("long_done_at", done_at, 32'd9549);
    chk("long_tx_idle", {31'd0, tx2}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
